// File: rtl/waveform_generator.sv
// Periodic square/sawtooth/triangle sample source with prescaled step
// rate and period-boundary shadowing of mode and duty.
module waveform_generator #(
  parameter int DATA_W     = 6,
  parameter int PRESCALE_W = 6,
  parameter int SCALE_W    = 6,
  parameter int PHASE_W    = 6
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [SCALE_W-1:0] scale,
  input  logic [PHASE_W-1:0] duty,
  output logic [DATA_W-1:0]  wave_out,
  output logic               period_start
);

  typedef enum logic [1:0] {
    M_SQ  = 2'b00,
    M_SAW = 2'b01,
    M_TRI = 2'b10,
    M_INV = 2'b11
  } mode_e;

  localparam int TW = PHASE_W - 1;

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [SCALE_W-1:0]    div_q, div_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [PHASE_W-1:0]    duty_q, duty_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_W-1:0]     wave_q, wave_d;
  logic                  ps_q, ps_d;
  logic                  fresh_q, fresh_d;

  logic [SCALE_W-1:0] scale_eff;
  logic               tick, step, wrap;
  logic [TW-1:0]      tri_t;
  logic [DATA_W-1:0]  saw_s, tri_s, sq_s, sample;

  assign tri_t = phase_q[PHASE_W-1] ? ~phase_q[TW-1:0]
                                    : phase_q[TW-1:0];

  if (DATA_W >= PHASE_W) begin : g_saw_up
    assign saw_s = DATA_W'(phase_q) << (DATA_W - PHASE_W);
  end else begin : g_saw_dn
    assign saw_s = phase_q[PHASE_W-1 -: DATA_W];
  end

  if (DATA_W >= TW) begin : g_tri_up
    assign tri_s = DATA_W'(tri_t) << (DATA_W - TW);
  end else begin : g_tri_dn
    assign tri_s = tri_t[TW-1 -: DATA_W];
  end

  assign sq_s = (phase_q < duty_q) ? '1 : '0;

  always_comb begin
    sample = '0;
    unique case (mode_q)
      M_SQ:  sample = sq_s;
      M_SAW: sample = saw_s;
      M_TRI: sample = tri_s;
      M_INV: sample = ~sq_s;
    endcase
  end

  always_comb begin
    scale_eff = (scale == '0) ? SCALE_W'(1) : scale;
    tick      = &pre_q;
    step      = tick && (div_q >= scale_eff - SCALE_W'(1));
    wrap      = step && (&phase_q);
  end

  // fresh marks "phase just became 0"; it is armed while disabled
  // so the first enabled sample also raises period_start.
  always_comb begin
    pre_d   = pre_q;
    div_d   = div_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    duty_d  = duty_q;
    wave_d  = wave_q;
    ps_d    = ps_q;
    fresh_d = fresh_q;
    if (!enable) begin
      pre_d   = '0;
      div_d   = '0;
      phase_d = '0;
      mode_d  = mode_e'(mode);
      duty_d  = duty;
      wave_d  = '0;
      ps_d    = 1'b0;
      fresh_d = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
      if (tick) begin
        div_d = step ? '0 : div_q + 1'b1;
      end
      if (step) begin
        phase_d = phase_q + 1'b1;
      end
      if (wrap) begin
        mode_d = mode_e'(mode);
        duty_d = duty;
      end
      wave_d  = sample;
      ps_d    = fresh_q;
      fresh_d = wrap;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      div_q   <= '0;
      phase_q <= '0;
      mode_q  <= M_SQ;
      duty_q  <= '0;
      wave_q  <= '0;
      ps_q    <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      wave_q  <= wave_d;
      ps_q    <= ps_d;
      fresh_q <= fresh_d;
    end
  end

  assign wave_out     = wave_q;
  assign period_start = ps_q;

endmodule
